miss_repair_arbiter: RTL and testbench

MISS_REPAIR_ARBITER -- requirements
Module: miss_repair_arbiter

---
 rtl/miss_repair_arbiter.sv | 159 +++++++++++++++
 tb/tb_miss_repair_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/miss_repair_arbiter.sv
// Miss repair arbiter: round-robin between icache and dcache misses,
// fetches one block from memory beat by beat and writes it to the winner.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   ic_repair_req/addr       icache miss request and missed address
//   dc_repair_req/addr       dcache miss request and missed address
//   mem_req/mem_addr/mem_ack block read request handshake
//   mem_rdata_valid/rdata    read beats, beat 0 first
//   fill_waddr/wdata/wmask   shared fill bus, non-zero only in WRITE
//   ic/dc_waddr_valid        fill strobe to each cache
//   ic/dc_repair_resolved    one-cycle completion pulse
//   busy                     arbiter not idle
module miss_repair_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 1024,
  parameter int BEAT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ic_repair_req,
  input  logic [ADDR_W-1:0]    ic_missed_addr,
  input  logic                 dc_repair_req,
  input  logic [ADDR_W-1:0]    dc_missed_addr,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_ack,
  input  logic                 mem_rdata_valid,
  input  logic [BEAT_W-1:0]    mem_rdata,
  output logic [ADDR_W-1:0]    fill_waddr,
  output logic [BLOCK_W-1:0]   fill_wdata,
  output logic [BLOCK_W/8-1:0] fill_wmask,
  output logic                 ic_waddr_valid,
  output logic                 dc_waddr_valid,
  output logic                 ic_repair_resolved,
  output logic                 dc_repair_resolved,
  output logic                 busy
);

  localparam int NB  = BLOCK_W / BEAT_W;
  localparam int KW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int OFF = $clog2(BLOCK_W / 8);
  localparam logic [KW-1:0] K_LAST = KW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_REQ,
    S_FILL,
    S_WRITE,
    S_RESOLVE
  } state_t;

  state_t               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [BLOCK_W-1:0]   blk_q;
  logic [KW-1:0]        k_q;
  logic                 gnt_dc_q;
  logic                 last_dc_q;
  logic                 mask_ic_q;
  logic                 mask_dc_q;

  logic ic_ok;
  logic dc_ok;
  logic pick_dc;

  // The side served last is held off for one idle cycle so a
  // requester that keeps its line up cannot be re-granted at once.
  assign ic_ok = ic_repair_req & ~mask_ic_q;
  assign dc_ok = dc_repair_req & ~mask_dc_q;

  // On a tie, DC wins unless it was the last one served.
  assign pick_dc = dc_ok & (~ic_ok | ~last_dc_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      blk_q     <= '0;
      k_q       <= '0;
      gnt_dc_q  <= 1'b0;
      last_dc_q <= 1'b0;
      mask_ic_q <= 1'b0;
      mask_dc_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          mask_ic_q <= 1'b0;
          mask_dc_q <= 1'b0;
          if (ic_ok | dc_ok) begin
            gnt_dc_q <= pick_dc;
            addr_q   <= pick_dc ? dc_missed_addr
                                : ic_missed_addr;
            k_q      <= '0;
            blk_q    <= '0;
            state_q  <= S_MEM_REQ;
          end
        end
        S_MEM_REQ: begin
          if (mem_ack) state_q <= S_FILL;
        end
        S_FILL: begin
          if (mem_rdata_valid) begin
            blk_q[32'(k_q) * BEAT_W +: BEAT_W] <= mem_rdata;
            // Counter parks on the last beat rather than wrapping.
            if (k_q == K_LAST) state_q <= S_WRITE;
            else               k_q     <= k_q + 1'b1;
          end
        end
        S_WRITE: begin
          state_q <= S_RESOLVE;
        end
        S_RESOLVE: begin
          last_dc_q <= gnt_dc_q;
          mask_dc_q <= gnt_dc_q;
          mask_ic_q <= ~gnt_dc_q;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so reset clears
  // them in the same instant it clears the state.
  always_comb begin
    mem_req            = 1'b0;
    mem_addr           = '0;
    fill_waddr         = '0;
    fill_wdata         = '0;
    fill_wmask         = '0;
    ic_waddr_valid     = 1'b0;
    dc_waddr_valid     = 1'b0;
    ic_repair_resolved = 1'b0;
    dc_repair_resolved = 1'b0;
    busy               = (state_q != S_IDLE);
    unique case (1'b1)
      (state_q == S_MEM_REQ): begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[ADDR_W-1:OFF], {OFF{1'b0}}};
      end
      (state_q == S_WRITE): begin
        fill_waddr     = addr_q;
        fill_wdata     = blk_q;
        fill_wmask     = '1;
        ic_waddr_valid = ~gnt_dc_q;
        dc_waddr_valid = gnt_dc_q;
      end
      (state_q == S_RESOLVE): begin
        ic_repair_resolved = ~gnt_dc_q;
        dc_repair_resolved = gnt_dc_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_miss_repair_arbiter.sv
// Directed bench for miss_repair_arbiter: single repairs, tie-break,
// slow memory with beat gaps, and reset in the middle of a fill.
module tb_miss_repair_arbiter;

  logic          clk;
  logic          rst;
  logic          ic_repair_req;
  logic [31:0]   ic_missed_addr;
  logic          dc_repair_req;
  logic [31:0]   dc_missed_addr;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ack;
  logic          mem_rdata_valid;
  logic [31:0]   mem_rdata;
  logic [31:0]   fill_waddr;
  logic [1023:0] fill_wdata;
  logic [127:0]  fill_wmask;
  logic          ic_waddr_valid;
  logic          dc_waddr_valid;
  logic          ic_repair_resolved;
  logic          dc_repair_resolved;
  logic          busy;

  int n_run;
  int n_fail;

  miss_repair_arbiter dut (
    .clk                (clk),
    .rst                (rst),
    .ic_repair_req      (ic_repair_req),
    .ic_missed_addr     (ic_missed_addr),
    .dc_repair_req      (dc_repair_req),
    .dc_missed_addr     (dc_missed_addr),
    .mem_req            (mem_req),
    .mem_addr           (mem_addr),
    .mem_ack            (mem_ack),
    .mem_rdata_valid    (mem_rdata_valid),
    .mem_rdata          (mem_rdata),
    .fill_waddr         (fill_waddr),
    .fill_wdata         (fill_wdata),
    .fill_wmask         (fill_wmask),
    .ic_waddr_valid     (ic_waddr_valid),
    .dc_waddr_valid     (dc_waddr_valid),
    .ic_repair_resolved (ic_repair_resolved),
    .dc_repair_resolved (dc_repair_resolved),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [1023:0] got,
                     input logic [1023:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1023:0] mk_blk(input logic [31:0] base);
    logic [1023:0] b;
    b = '0;
    for (int k = 0; k < 32; k++) b[k*32 +: 32] = base + k;
    return b;
  endfunction

  task automatic wait_mem_req();
    int n;
    n = 0;
    while (!mem_req && n < 50) begin
      step();
      n++;
    end
    chk("mem_req_seen", mem_req, 1'b1);
  endtask

  // Serve one complete repair as the memory; beat k carries base+k.
  task automatic serve(input bit dc, input logic [31:0] a,
                       input int dly, input int gap,
                       input logic [31:0] base);
    logic [1023:0] eb;
    logic [31:0]   al;
    eb = mk_blk(base);
    al = {a[31:7], 7'h00};
    wait_mem_req();
    chk("busy", busy, 1'b1);
    chk("mem_addr", mem_addr, al);
    if (dc) dc_missed_addr = 32'h1234_5678;
    else    ic_missed_addr = 32'h1234_5678;
    for (int i = 0; i < dly; i++) begin
      mem_rdata_valid = 1'b1;
      mem_rdata       = 32'hBAD0_0000;
      step();
      chk("mem_addr_hold", {mem_req, mem_addr}, {1'b1, al});
    end
    mem_rdata_valid = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k == 31)
        chk("no_early_write", {ic_waddr_valid, dc_waddr_valid}, 2'b00);
      mem_rdata_valid = 1'b1;
      mem_rdata       = base + k;
      step();
      mem_rdata_valid = 1'b0;
      if (k < 31) repeat (gap) step();
    end
    chk("waddr_valid", {ic_waddr_valid, dc_waddr_valid},
        dc ? 2'b01 : 2'b10);
    chk("fill_waddr", fill_waddr, a);
    chk("fill_wdata", fill_wdata, eb);
    chk("fill_wmask", fill_wmask, {128{1'b1}});
    step();
    chk("write_one_cycle", {ic_waddr_valid, dc_waddr_valid}, 2'b00);
    chk("resolved", {ic_repair_resolved, dc_repair_resolved},
        dc ? 2'b01 : 2'b10);
    chk("fill_zero_out", {fill_waddr, fill_wmask, fill_wdata}, '0);
    step();
    chk("resolved_one_cycle",
        {ic_repair_resolved, dc_repair_resolved}, 2'b00);
  endtask

  initial begin
    n_run           = 0;
    n_fail          = 0;
    rst             = 1'b1;
    ic_repair_req   = 1'b0;
    ic_missed_addr  = '0;
    dc_repair_req   = 1'b0;
    dc_missed_addr  = '0;
    mem_ack         = 1'b0;
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;

    step();
    step();
    chk("rst_outs", {mem_req, busy, ic_waddr_valid, dc_waddr_valid,
        ic_repair_resolved, dc_repair_resolved}, 6'b0);
    chk("rst_fill", {fill_waddr, fill_wmask, fill_wdata}, '0);
    rst = 1'b0;
    step();

    // DC alone, fast memory; DC keeps requesting one cycle afterwards.
    dc_missed_addr = 32'hAABB_CCDD;
    dc_repair_req  = 1'b1;
    serve(1'b1, 32'hAABB_CCDD, 0, 0, 32'h0);
    chk("idle_after", busy, 1'b0);
    step();
    chk("no_regrant", {busy, mem_req}, 2'b00);
    dc_repair_req = 1'b0;
    step();

    // Tie out of reset: DC first, then IC straight away.
    rst = 1'b1;
    step();
    rst = 1'b0;
    ic_missed_addr = 32'h1000_0044;
    dc_missed_addr = 32'h2000_0088;
    ic_repair_req  = 1'b1;
    dc_repair_req  = 1'b1;
    serve(1'b1, 32'h2000_0088, 0, 0, 32'h100);
    dc_repair_req = 1'b0;
    step();
    chk("ic_immediate", {mem_req, mem_addr}, {1'b1, 32'h1000_0000});
    serve(1'b0, 32'h1000_0044, 0, 0, 32'h200);
    ic_repair_req = 1'b0;
    step();

    // Slow memory: ack after 5 cycles, beats every other cycle.
    dc_missed_addr = 32'hAABB_CCDD;
    dc_repair_req  = 1'b1;
    serve(1'b1, 32'hAABB_CCDD, 5, 1, 32'h0);
    dc_repair_req = 1'b0;
    step();
    step();

    // Reset after beat 10, then a fresh repair.
    dc_missed_addr = 32'h0000_3F10;
    dc_repair_req  = 1'b1;
    wait_mem_req();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      mem_rdata_valid = 1'b1;
      mem_rdata       = 32'hF000_0000 + k;
      step();
    end
    mem_rdata_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_outs", {mem_req, busy, ic_waddr_valid, dc_waddr_valid,
        ic_repair_resolved, dc_repair_resolved}, 6'b0);
    chk("midrst_fill", {fill_waddr, fill_wmask, fill_wdata}, '0);
    step();
    step();
    chk("midrst_no_write", {ic_waddr_valid, dc_waddr_valid}, 2'b00);
    rst = 1'b0;
    serve(1'b1, 32'h0000_3F10, 0, 0, 32'h55);
    dc_repair_req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
